divider_multi: RTL
==================

Name: divider_multi

Overview:
Parametrised sequential integer divider. It is the next generation of the team's single-mode restoring divider and adds several features:
- selectable signed/unsigned operation per request
- a configurable number of quotient bits resolved per cycle
- explicit busy status
- signed-overflow detection
- result caching
It serves as the shared division resource for datapath blocks. Requests use a start/busy/valid handshake.

Parameters:
WIDTH, 32, operand and result width in bits; must be >= 2.
BITS_PER_CYCLE, 1, quotient bits resolved per iteration cycle; WIDTH must be a multiple of it; allowed values are 1, 2, 4.
SIGNED_EN, 1, 1 enables signed_op; 0 ties signed mode off and signed_op is ignored.
CACHING, 1, 1 lets a request identical to the last completed one return in 1 cycle.
INIT_VLD, 0, reset value of valid.

Ports:
clk  in  1  clock; all state updates on posedge.
rst  in  1  asynchronous, active-high reset.
start  in  1  request strobe; sampled on posedge and accepted only when busy=0.
signed_op  in  1  1 = two's-complement division, 0 = unsigned; latched at accept.
dividend  in  WIDTH  numerator; latched at accept.
divisor  in  WIDTH  denominator; latched at accept.
quotient  out  WIDTH  result quotient.
remainder  out  WIDTH  result remainder.
zeroErr  out  1  last result was a divide-by-zero.
overflow  out  1  last result was signed MIN / -1.
busy  out  1  operation in progress; start is ignored while high.
valid  out  1  quotient/remainder/flags hold a completed result.

Behaviour:
- Reset (async, rst=1):
  - quotient=0, remainder=0, zeroErr=0, overflow=0, busy=0, valid=INIT_VLD.
  - Cache invalidated; FSM to IDLE.
  - Applies mid-operation; the aborted result is discarded.
- Accept: at a posedge with start=1 and busy=0 (edge T0).
  - Operands and mode are latched.
  - valid, zeroErr and overflow clear at T0.
- FSM states: IDLE, ITER, FIX.
  - IDLE -> ITER on a normal accept; busy=1 from T0.
  - IDLE -> IDLE with a 1-cycle result for the special cases below (busy=1 for exactly one cycle, valid after T1).
  - ITER: N = WIDTH/BITS_PER_CYCLE cycles, edges T1..TN.
  - Each ITER cycle does BITS_PER_CYCLE restoring shift-subtract steps on the operand magnitudes.
  - FIX at edge TN+1 applies sign correction, loads the outputs, sets valid=1 and busy=0, then returns to IDLE.
  - Normal latency: valid rises N+1 cycles after accept.
- Special cases, all resolved at T1 (valid after T1), checked in this priority order:
  1. Divisor==0: zeroErr=1, quotient=all ones, remainder=dividend (both modes).
  2. Signed and dividend==MIN and divisor==-1: overflow=1, quotient=MIN, remainder=0.
  3. CACHING=1 and the cache is valid and {dividend, divisor, signed_op} equals the last completed request: outputs reloaded from the cache, flags as cached.
- Signed arithmetic rules:
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
  - Identity q*divisor + r == dividend holds whenever zeroErr=0 and overflow=0.
- Unsigned arithmetic: standard floor division.
- Cache: updated on every completion, including zero and overflow results. It is invalid after reset even when INIT_VLD=1.
- Output stability:
  - valid stays high and outputs stay stable until the next accept.
  - Outputs keep the old values while busy and change only on completion.
- Input changes while busy are ignored. start held high while busy is ignored and is not queued.
- start=1 in the same cycle that FIX completes is not accepted, because busy=1 at that edge. It is accepted on the next edge.

Test Plan:
All scenarios use WIDTH=32, BITS_PER_CYCLE=2, INIT_VLD=0 (N=16).
1. Unsigned 12344235 / 2343 -> valid 17 cycles after accept; q=5268, r=1311; busy high for 17 cycles.
2. Signed -7 / 2 (0xFFFFFFF9 / 2) -> q=0xFFFFFFFD (-3), r=0xFFFFFFFF (-1). The same operands unsigned give q=0x7FFFFFFC, r=1.
3. 4624653 / 0 -> valid after 1 cycle; zeroErr=1, q=0xFFFFFFFF, r=4624653. A follow-up request clears zeroErr at accept.
4. Signed 0x80000000 / 0xFFFFFFFF -> valid after 1 cycle; overflow=1, q=0x80000000, r=0.
5. 59049 / 3 twice -> first result after 17 cycles, second after 1 cycle, both q=19683, r=0. Then pulse start again 3 cycles into a busy period -> ignored, result unchanged.
6. Assert rst 5 cycles into 59049 / 3 -> immediately busy=0, valid=0, outputs 0. Repeating 59049 / 3 then takes the full 17 cycles, because the cache was cleared.

Source files
------------

// File: rtl/divider_multi.sv
// Sequential restoring divider with per-request signed/unsigned mode,
// configurable quotient bits per cycle, divide-by-zero and signed-overflow
// flags, and a one-entry result cache for repeated requests.
//
// state | meaning
// IDLE  | waiting for start; also holds one-cycle special results (busy=1)
// ITER  | BITS_PER_CYCLE restoring shift-subtract steps per cycle on magnitudes
// FIX   | sign correction, load outputs, raise valid, drop busy
module divider_multi #(
   parameter int WIDTH          = 32,
   parameter int BITS_PER_CYCLE = 1,
   parameter int SIGNED_EN      = 1,
   parameter int CACHING        = 1,
   parameter bit INIT_VLD       = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             signed_op,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             zeroErr,
   output logic             overflow,
   output logic             busy,
   output logic             valid
);

   localparam int N     = WIDTH / BITS_PER_CYCLE;
   localparam int CNT_W = $clog2(N + 1);
   localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

   state_t state, state_nxt;

   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] q_acc, rem_acc, dmag;
   logic [WIDTH-1:0] dd_q, ds_q;
   logic             sg_q, neg_q, neg_r, sel_zero, sel_ovf;

   logic             cache_vld, cache_sg, cache_z, cache_o;
   logic [WIDTH-1:0] cache_dd, cache_ds, cache_q, cache_r;

   logic             accept, sgn_in, is_zero_in, is_ovf_in, hit_in, special_in;
   logic             quick_done, fix_done, done;
   logic [WIDTH:0]   r_t;
   logic [WIDTH-1:0] q_t;
   logic [WIDTH-1:0] res_q, res_r;
   logic             res_z, res_o;

   assign accept     = start && !busy;
   assign sgn_in     = (SIGNED_EN != 0) && signed_op;
   assign is_zero_in = (divisor == '0);
   assign is_ovf_in  = sgn_in && (dividend == MIN_VAL) && (divisor == {WIDTH{1'b1}});
   assign hit_in     = (CACHING != 0) && cache_vld && (dividend == cache_dd) &&
                       (divisor == cache_ds) && (sgn_in == cache_sg);
   assign special_in = is_zero_in || is_ovf_in || hit_in;

   // Special cases never leave IDLE; busy alone marks their one pending cycle.
   assign quick_done = (state == IDLE) && busy;
   assign fix_done   = (state == FIX);
   assign done       = quick_done || fix_done;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept && !special_in) state_nxt = ITER;
         ITER:    if (cnt == '0) state_nxt = FIX;
         FIX:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // BITS_PER_CYCLE restoring steps; r_t carries one extra bit for the shifted partial.
   always_comb begin
      r_t = {1'b0, rem_acc};
      q_t = q_acc;
      for (int i = 0; i < BITS_PER_CYCLE; i++) begin
         r_t = {r_t[WIDTH-1:0], q_t[WIDTH-1]};
         q_t = {q_t[WIDTH-2:0], 1'b0};
         if (r_t >= {1'b0, dmag}) begin
            r_t     = r_t - {1'b0, dmag};
            q_t[0]  = 1'b1;
         end
      end
   end

   // Completion result: sign-corrected iteration, zero/overflow constants, or cache.
   always_comb begin
      res_q = cache_q;
      res_r = cache_r;
      res_z = cache_z;
      res_o = cache_o;
      if (fix_done) begin
         res_q = neg_q ? -q_acc : q_acc;
         res_r = neg_r ? -rem_acc : rem_acc;
         res_z = 1'b0;
         res_o = 1'b0;
      end else if (sel_zero) begin
         res_q = {WIDTH{1'b1}};
         res_r = dd_q;
         res_z = 1'b1;
         res_o = 1'b0;
      end else if (sel_ovf) begin
         res_q = MIN_VAL;
         res_r = '0;
         res_z = 1'b0;
         res_o = 1'b1;
      end
   end

   // Operand capture and iteration datapath; the timer counts down to zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt      <= '0;
         q_acc    <= '0;
         rem_acc  <= '0;
         dmag     <= '0;
         dd_q     <= '0;
         ds_q     <= '0;
         sg_q     <= 1'b0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         sel_zero <= 1'b0;
         sel_ovf  <= 1'b0;
      end else if (accept) begin
         cnt      <= CNT_W'(N - 1);
         q_acc    <= (sgn_in && dividend[WIDTH-1]) ? -dividend : dividend;
         rem_acc  <= '0;
         dmag     <= (sgn_in && divisor[WIDTH-1]) ? -divisor : divisor;
         dd_q     <= dividend;
         ds_q     <= divisor;
         sg_q     <= sgn_in;
         neg_q    <= sgn_in && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
         neg_r    <= sgn_in && dividend[WIDTH-1];
         sel_zero <= is_zero_in;
         sel_ovf  <= is_ovf_in;
      end else if (state == ITER) begin
         q_acc   <= q_t;
         rem_acc <= r_t[WIDTH-1:0];
         if (cnt != '0) cnt <= cnt - CNT_W'(1);
      end
   end

   // Result cache; refreshed on every completion and invalidated by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cache_vld <= 1'b0;
         cache_sg  <= 1'b0;
         cache_dd  <= '0;
         cache_ds  <= '0;
         cache_q   <= '0;
         cache_r   <= '0;
         cache_z   <= 1'b0;
         cache_o   <= 1'b0;
      end else if (done) begin
         cache_vld <= 1'b1;
         cache_sg  <= sg_q;
         cache_dd  <= dd_q;
         cache_ds  <= ds_q;
         cache_q   <= res_q;
         cache_r   <= res_r;
         cache_z   <= res_z;
         cache_o   <= res_o;
      end
   end

   // Output registers: flags clear at accept, values change only on completion.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         quotient  <= '0;
         remainder <= '0;
         zeroErr   <= 1'b0;
         overflow  <= 1'b0;
         busy      <= 1'b0;
         valid     <= INIT_VLD;
      end else if (accept) begin
         zeroErr  <= 1'b0;
         overflow <= 1'b0;
         busy     <= 1'b1;
         valid    <= 1'b0;
      end else if (done) begin
         quotient  <= res_q;
         remainder <= res_r;
         zeroErr   <= res_z;
         overflow  <= res_o;
         busy      <= 1'b0;
         valid     <= 1'b1;
      end
   end

endmodule
